// File: rtl/alu_pkg.sv
// Shared defaults and configuration check for the skewed pipelined adder/subtractor.
package alu_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder; also exposes the carry into the segment MSB
// so the final stage can form signed overflow.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[SEG];
  assign cmsb = carry[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Skewed pipelined add/subtract: stage k adds slice k, carrying untouched operand
// slices and finished sum slices forward, with per-stage valid/ready flow control.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  logic [WIDTH-1:0]  src_a  [STAGES];
  logic [WIDTH-1:0]  src_b  [STAGES];
  logic [WIDTH-1:0]  src_p  [STAGES];
  logic [STAGES-1:0] src_c;

  logic [WIDTH-1:0]  pipe_a [STAGES];
  logic [WIDTH-1:0]  pipe_b [STAGES];
  logic [WIDTH-1:0]  pipe_p [STAGES];
  logic [STAGES-1:0] pipe_c;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  // Ready ripples back from out_ready: a stage can take new data if it is empty
  // or its own content is moving on this cycle.
  always_comb begin
    logic room;
    adv  = '0;
    load = '0;
    room = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld[k] & room;
      room   = ~vld[k] | adv[k];
    end
    in_ready = room;
    load[0]  = in_valid & room;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= load | (vld & ~adv);
  end

  assign out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;
    logic [WIDTH-1:0] next_p;

    if (k == 0) begin : g_first
      assign src_a[k] = a;
      assign src_b[k] = b_eff;
      assign src_p[k] = '0;
      assign src_c[k] = cin_eff;
    end else begin : g_next
      assign src_a[k] = pipe_a[k-1];
      assign src_b[k] = pipe_b[k-1];
      assign src_p[k] = pipe_p[k-1];
      assign src_c[k] = pipe_c[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (src_a[k][k*SEG +: SEG]),
      .b    (src_b[k][k*SEG +: SEG]),
      .cin  (src_c[k]),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      next_p                  = src_p[k];
      next_p[k*SEG +: SEG]    = seg_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] p_q;
      logic             c_q;

      always_ff @(posedge clk) begin
        if (load[k]) begin
          a_q <= src_a[k];
          b_q <= src_b[k];
          p_q <= next_p;
          c_q <= seg_cout;
        end
      end

      assign pipe_a[k] = a_q;
      assign pipe_b[k] = b_q;
      assign pipe_p[k] = p_q;
      assign pipe_c[k] = c_q;
    end else begin : g_last
      // Final stage registers the visible result so it holds while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (load[k]) begin
          sum  <= next_p;
          cout <= seg_cout;
          ovf  <= seg_cmsb ^ seg_cout;
          zero <= (next_p == '0);
        end
      end

      assign pipe_a[k] = '0;
      assign pipe_b[k] = '0;
      assign pipe_p[k] = '0;
      assign pipe_c[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: queue-based reference model plus
// directed corner cases, flow-control and mid-flight reset scenarios.
module tb_pipelined_addsub;

  localparam int W      = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  logic         hold_v = 1'b0;
  logic [W-1:0] hold_sum;
  logic [2:0]   hold_flags;

  pipelined_addsub #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic mc);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   ext;
    bb     = ms ? ~mb : mb;
    ext    = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms ? 1'b1 : mc);
    r.sum  = ext[W-1:0];
    r.cout = ext[W];
    r.ovf  = (ma[W-1] == bb[W-1]) && (r.sum[W-1] != ma[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference compare, every cycle while out of reset.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("in_ready", in_ready, 32'((exp_q.size() < STAGES) || out_ready));
      chk("inflight_bound", 32'(exp_q.size() <= STAGES), 32'd1);
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, hold_sum);
        chk("hold_flags", {cout, ovf, zero}, hold_flags);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          chk("zero", zero, e.zero);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      hold_v     = out_valid && !out_ready;
      hold_sum   = sum;
      hold_flags = {cout, ovf, zero};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
    end
  end

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 2) @(negedge clk);
  endtask

  task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                        input logic ts, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input logic ez, input string nm);
    int lat;
    bit got;
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_op; sub = ts; cin = tc;
    @(negedge clk);
    chk({nm, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_zero"}, zero, ez);
  endtask

  task automatic burst8();
    int sent = 0;
    int got  = 0;
    drain();
    for (int t = 0; t < 40 && got < 8; t++) begin
      @(posedge clk); #1;
      out_ready = !(t >= 2 && t <= 10);
      in_valid  = (sent < 8);
      a = 32'(sent); b = 32'(sent); sub = 1'b0; cin = 1'b0;
      @(negedge clk);
      if (t == 3) chk("burst_ready_t3", in_ready, 1);
      if (t == 4) chk("burst_ready_t4", in_ready, 0);
      if (t == 10) chk("burst_ready_t10", in_ready, 0);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("burst_sum", sum, 32'(2 * got));
        got++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("burst_count", 32'(got), 32'd8);
  endtask

  task automatic reset_mid();
    int n = 0;
    int wc = 0;
    int seen = 0;
    drain();
    @(posedge clk); #1;
    out_ready = 1'b0;
    while (n < 3 && wc < 20) begin
      in_valid = 1'b1; a = 32'(100 + n); b = 32'd1; sub = 1'b0; cin = 1'b0;
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk); #1;
      wc++;
    end
    in_valid = 1'b0;
    chk("rst_loaded", 32'(n), 32'd3);
    wc = 0;
    while (!out_valid && wc < 10) begin
      @(negedge clk);
      wc++;
    end
    chk("rst_pre_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    hold_v = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_stale", 32'(seen), 32'd0);
    single(32'd20, 32'd22, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0, "post_rst");
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = rand_op();
      b         = rand_op();
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_flags", {cout, ovf, zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    single(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "ovf_pos");
    single(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "carry_all");
    single(32'd5, 32'd5, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_zero");
    single(32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    single(32'd3, 32'd4, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_cin_ignored");

    burst8();
    reset_mid();
    run_random(800);
    drain();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 2).
REQ-002 Parameter STAGES, default 4, number of pipeline segments; WIDTH SHALL be divisible by STAGES, SEG = WIDTH/STAGES.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand beat present.
REQ-006 in_ready  out  1  block accepts beat this cycle.
REQ-007 a  in  WIDTH  signed operand A.
REQ-008 b  in  WIDTH  signed operand B.
REQ-009 sub  in  1  0 = A+B+cin, 1 = A-B.
REQ-010 cin  in  1  carry-in, used only when sub=0.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  WIDTH  signed result.
REQ-014 cout  out  1  carry out of bit WIDTH-1.
REQ-015 ovf  out  1  signed two's-complement overflow.
REQ-016 zero  out  1  sum == 0.

Function
REQ-017 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-018 Effective operation: sum = a + (sub ? ~b : b) + (sub ? 1 : cin), modulo 2^WIDTH.
REQ-019 Stage k (0..STAGES-1) SHALL add bit slice [k*SEG +: SEG] using carry registered from stage k-1; stage 0 takes the effective carry-in.
REQ-020 Unprocessed operand slices and completed sum slices SHALL be carried forward in stage registers (skewed pipeline); no slice is added twice.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stall occurs.
REQ-022 cout = carry out of the final segment; ovf = carry into MSB XOR carry out of MSB; zero computed from the full final sum.
REQ-023 Per-stage valid bit; stage k advances when stage k+1 is empty or advancing; last stage advances on out_ready.
REQ-024 in_ready = stage 0 empty or stage 0 advancing (bubbles collapse; full throughput of one beat/cycle when out_ready=1).
REQ-025 With out_ready held low, at most STAGES beats in flight; in_ready SHALL drop in the cycle after the pipe fills.
REQ-026 Results emitted in acceptance order; no beat dropped or duplicated.
REQ-027 sum/cout/ovf/zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Simultaneous accept and deliver on a full pipe SHALL be legal and lossless.

Reset
REQ-029 On rst_n=0, all stage valid bits clear immediately; out_valid=0, sum=0, cout=0, ovf=0, zero=0.
REQ-030 in_ready SHALL read 1 during and after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; no result from before reset appears afterwards.
REQ-032 Datapath registers other than outputs need no reset.

Structure
REQ-033 Shared package alu_pkg SHALL hold default WIDTH, default STAGES and the WIDTH%STAGES==0 elaboration check.
REQ-034 One sub-module, adder_segment: combinational SEG-bit ripple adder (a, b, cin -> sum, cout, carry into MSB), instanced once per stage.

Verification (WIDTH=32, STAGES=4)
REQ-035 a=0x7FFFFFFF, b=1, sub=0, cin=0 -> sum=0x80000000, ovf=1, cout=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-036 a=0xFFFFFFFF, b=0, sub=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0 (carry crosses all segments).
REQ-037 a=5, b=5, sub=1 -> sum=0, cout=1, zero=1; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-038 8 back-to-back beats (a=i, b=i), out_ready low from cycle 2 to 10 -> in_ready low once 4 in flight, all 8 results 2*i delivered in order.
REQ-039 rst_n pulsed low with 3 beats in flight -> out_valid=0 at once, no stale result after release, next beat emerges 4 cycles after acceptance.
